// File: rtl/render_sequencer_if.sv
// Command-byte and line-engine handshake bundle for render_sequencer.
// The master side is the sequencer. The slave side is the environment (byte source plus line engine).
interface render_sequencer_if;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       cmd_ready;
    logic       ln_start;
    logic [7:0] ln_x0, ln_y0, ln_x1, ln_y1;
    logic       ln_done;
    logic       busy;
    logic       obj_done;
    logic       err_type;
    logic       err_timeout;

    modport master (
        input  cmd_valid, cmd_byte, ln_done,
        output cmd_ready, ln_start, ln_x0, ln_y0, ln_x1, ln_y1,
               busy, obj_done, err_type, err_timeout
    );

    modport slave (
        output cmd_valid, cmd_byte, ln_done,
        input  cmd_ready, ln_start, ln_x0, ln_y0, ln_x1, ln_y1,
               busy, obj_done, err_type, err_timeout
    );
endinterface

// File: rtl/render_sequencer.sv
// Byte-serial object command controller: collects vertices and issues line segments one at a time.
// Optional feature macro RU_RECT_EN enables type 8'h04 (rect, 4 bytes, 4 segments).
module render_sequencer #(
    parameter logic [15:0] MAX_WAIT = 16'hFFFF
) (
    input logic ACLK,
    input logic ARESETn,
    render_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {T_PT, T_LN, T_TR, T_RC} obj_t;

    state_t          state, state_nxt;
    obj_t            obj, obj_dec;
    logic            type_ok;
    logic [2:0]      bcnt, last_byte;
    logic [1:0]      seg, seg_nxt, last_seg;
    logic [5:0][7:0] vtx, vtx_nxt;
    logic [15:0]     wcnt;
    logic [31:0]     pts, ep;
    logic            accept, timeout;
    logic            err_type_q, err_timeout_q;

    // Packed result is {x0, y0, x1, y1}. The vertex vector is ordered X0, Y0, X1, Y1, X2, Y2.
    function automatic logic [31:0] seg_pts(input obj_t t, input logic [1:0] k,
                                            input logic [5:0][7:0] v);
        case (t)
            T_PT: return {v[0], v[1], v[0], v[1]};
            T_LN: return {v[0], v[1], v[2], v[3]};
            T_TR: case (k)
                2'd0:    return {v[0], v[1], v[2], v[3]};
                2'd1:    return {v[2], v[3], v[4], v[5]};
                default: return {v[4], v[5], v[0], v[1]};
            endcase
            default: case (k)
                2'd0:    return {v[0], v[1], v[2], v[1]};
                2'd1:    return {v[2], v[1], v[2], v[3]};
                2'd2:    return {v[2], v[3], v[0], v[3]};
                default: return {v[0], v[3], v[0], v[1]};
            endcase
        endcase
    endfunction

    assign bus.cmd_ready = (state == S_IDLE) || (state == S_COLLECT);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign timeout       = (MAX_WAIT != 16'd0) && (wcnt + 16'd1 == MAX_WAIT);

    always_comb begin
        type_ok = 1'b1;
        obj_dec = T_PT;
        case (bus.cmd_byte)
            8'h01: obj_dec = T_PT;
            8'h02: obj_dec = T_LN;
            8'h03: obj_dec = T_TR;
`ifdef RU_RECT_EN
            8'h04: obj_dec = T_RC;
`endif
            default: type_ok = 1'b0;
        endcase
    end

    always_comb begin
        last_byte = 3'd1;
        last_seg  = 2'd0;
        case (obj)
            T_PT: begin last_byte = 3'd1; last_seg = 2'd0; end
            T_LN: begin last_byte = 3'd3; last_seg = 2'd0; end
            T_TR: begin last_byte = 3'd5; last_seg = 2'd2; end
            T_RC: begin last_byte = 3'd3; last_seg = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        seg_nxt   = seg;
        vtx_nxt   = vtx;
        case (state)
            S_IDLE:    if (accept && type_ok) state_nxt = S_COLLECT;
            S_COLLECT: if (accept) begin
                vtx_nxt[bcnt] = bus.cmd_byte;
                if (bcnt == last_byte) state_nxt = S_ISSUE;
            end
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT:    if (bus.ln_done) begin
                if (seg == last_seg) state_nxt = S_DONE;
                else begin
                    seg_nxt   = seg + 2'd1;
                    state_nxt = S_ISSUE;
                end
            end else if (timeout) begin
                state_nxt = S_IDLE;
            end
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Endpoints are computed from next-cycle vertex/segment values so ISSUE sees them immediately.
    assign pts = seg_pts(obj, seg_nxt, vtx_nxt);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state         <= S_IDLE;
            obj           <= T_PT;
            bcnt          <= 3'd0;
            seg           <= 2'd0;
            vtx           <= '0;
            wcnt          <= 16'd0;
            ep            <= 32'd0;
            err_type_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            seg           <= seg_nxt;
            vtx           <= vtx_nxt;
            err_type_q    <= (state == S_IDLE) && accept && !type_ok;
            err_timeout_q <= (state == S_WAIT) && !bus.ln_done && timeout;
            if (state == S_IDLE && accept) begin
                seg  <= 2'd0;
                bcnt <= 3'd0;
                if (type_ok) obj <= obj_dec;
            end else if (state == S_COLLECT && accept) begin
                bcnt <= bcnt + 3'd1;
            end
            if (state == S_ISSUE) wcnt <= 16'd0;
            else if (state == S_WAIT && !bus.ln_done) wcnt <= wcnt + 16'd1;
            if (state_nxt == S_ISSUE) ep <= pts;
        end
    end

    assign bus.ln_start    = (state == S_ISSUE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.obj_done    = (state == S_DONE);
    assign bus.err_type    = err_type_q;
    assign bus.err_timeout = err_timeout_q;
    assign {bus.ln_x0, bus.ln_y0, bus.ln_x1, bus.ln_y1} = ep;
endmodule
